// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the 8x8 quadrant-scheduled multiplier:
// FSM states, 4x4 cell kind codes, quadrant indices and their shift amounts.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] KIND_EXACT = 2'd0;
  localparam logic [1:0] KIND_N1    = 2'd1;
  localparam logic [1:0] KIND_R1    = 2'd2;
  localparam logic [1:0] KIND_R2    = 2'd3;

  // Bit 1 selects the A nibble, bit 0 the B nibble.
  localparam logic [1:0] Q_LL = 2'd0;
  localparam logic [1:0] Q_LH = 2'd1;
  localparam logic [1:0] Q_HL = 2'd2;
  localparam logic [1:0] Q_HH = 2'd3;

  function automatic logic [3:0] quad_shift(input logic [1:0] q);
    logic [3:0] s;
    case (q)
      Q_LL:    s = 4'd0;
      Q_LH:    s = 4'd4;
      Q_HL:    s = 4'd4;
      default: s = 4'd8;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult_8x8_quad_sched_quad_acc.sv
// 16-bit quadrant accumulator: clear on accept, then combine shifted terms.
// QUAD_OR_ACC_EN selects carry-free OR combining instead of addition.
module quad_acc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  term,
  input  logic [3:0]  shift,
  output logic [15:0] acc
);

  logic [15:0] shifted;
  logic [15:0] combined;

  assign shifted = {8'h00, term} << shift;

`ifdef QUAD_OR_ACC_EN
  assign combined = acc | shifted;
`else
  assign combined = acc + shifted;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= 16'h0000;
    end else if (clr) begin
      acc <= 16'h0000;
    end else if (en) begin
      acc <= combined;
    end
  end

endmodule

// File: rtl/mult_8x8_quad_sched.sv
// 8x8 unsigned multiplier time-sharing one external 4x4 cell over four quadrants.
// Optional macro QUAD_OR_ACC_EN (in quad_acc) switches to OR accumulation.
module mult_8x8_quad_sched
  import mult_sched_pkg::*;
#(
  parameter int SKIP_ZERO = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [7:0]       kind,
  output logic             mul_en,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  output logic [1:0]       mul_kind,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      r,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt
);

  state_t     state, state_nx;
  logic [7:0] a_q, b_q, kind_q;
  logic [3:0] mask_q, mask_in;
  logic [1:0] qidx, qidx_nx;
  logic       accept;
  logic [2:0] nq_idle, nq_iss;

  // Returns {found, index} of the first set mask bit at or above 'from'.
  function automatic logic [2:0] next_quad(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && m[i]) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  assign mask_in = (SKIP_ZERO != 0) ?
                   {(|a[7:4]) & (|b[7:4]), (|a[7:4]) & (|b[3:0]),
                    (|a[3:0]) & (|b[7:4]), (|a[3:0]) & (|b[3:0])} : 4'hF;

  assign nq_idle = next_quad(mask_in, 3'd0);
  assign nq_iss  = next_quad(mask_q, {1'b0, qidx} + 3'd1);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx  = state;
    qidx_nx   = qidx;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_en    = 1'b0;
    mul_a     = 4'h0;
    mul_b     = 4'h0;
    mul_kind  = 2'b00;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (nq_idle[2]) begin
            state_nx = ISSUE;
            qidx_nx  = nq_idle[1:0];
          end else begin
            state_nx = DONE;
          end
        end
      end
      ISSUE: begin
        mul_en   = 1'b1;
        mul_a    = qidx[1] ? a_q[7:4] : a_q[3:0];
        mul_b    = qidx[0] ? b_q[7:4] : b_q[3:0];
        mul_kind = kind_q[{qidx, 1'b0} +: 2];
        if (nq_iss[2]) qidx_nx = nq_iss[1:0];
        else           state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      qidx      <= 2'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      kind_q    <= 8'h00;
      mask_q    <= 4'h0;
      issue_cnt <= '0;
    end else begin
      state <= state_nx;
      qidx  <= qidx_nx;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        kind_q <= kind;
        mask_q <= mask_in;
      end
      if (mul_en && (issue_cnt != {CNT_W{1'b1}}))
        issue_cnt <= issue_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  quad_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (mul_en),
    .term  (mul_p),
    .shift (quad_shift(qidx)),
    .acc   (r)
  );

endmodule

// File: doc/mult_8x8_quad_sched.md
# mult_8x8_quad_sched

Sequential scheduler that computes an 8x8 unsigned product by time-sharing one external 4x4 multiplier cell across the four nibble quadrants. Each quadrant carries its own per-transaction multiplier-kind code, so exact and approximate 4x4 variants can be mixed. The block captures an operand pair over a valid/ready handshake, issues up to four quadrant products, accumulates them into a 16-bit result, and holds the result until downstream accepts it. It sits between a request source and a single shared 4x4 multiplier instance in the approximate-multiplier library.

## Interface
Parameters:
- SKIP_ZERO, default 1: when 1, a quadrant whose A or B nibble is zero is not issued and contributes 0.
- CNT_W, default 16: width of the issued-quadrant performance counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- a  in  8  multiplicand.
- b  in  8  multiplier.
- kind  in  8  per-quadrant kind codes: [1:0] LL, [3:2] LH (A lo x B hi), [5:4] HL (A hi x B lo), [7:6] HH.
- mul_en  out  1  shared multiplier is in use this cycle.
- mul_a  out  4  nibble of A to the shared cell.
- mul_b  out  4  nibble of B to the shared cell.
- mul_kind  out  2  variant select to the shared cell.
- mul_p  in  8  shared-cell product; combinational, sampled at the same edge.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- r  out  16  product.
- busy  out  1  state is not IDLE.
- issue_cnt  out  CNT_W  total quadrants issued since reset; saturates at all-ones.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE: in_ready=1.
  - If in_valid is high at the edge, capture a, b, kind and clear the accumulator.
  - Compute the issue mask. A bit is set unless SKIP_ZERO=1 and either nibble of that quadrant is 0.
  - Mask non-zero: go to ISSUE, pointing at the lowest set quadrant.
  - Mask zero: go to DONE with r=0.
- ISSUE: one quadrant per cycle in the order LL, LH, HL, HH, skipping masked-out quadrants.
  - mul_en=1. mul_a, mul_b and mul_kind are driven from the captured operands and the quadrant index.
  - At the edge, mul_p is accumulated with a shift of 0 (LL), 4 (LH, HL) or 8 (HH), and issue_cnt increments (saturating).
  - After the last set quadrant, go to DONE.
- DONE: out_valid=1 and r is stable.
  - On out_valid && out_ready, go to IDLE.
  - in_ready=0; there is no overlap between a result and the next accept.
- Accumulation:
  - Each term is zero-extended to 16 bits before shifting.
  - The sum is taken modulo 2^16. With all-exact kinds it cannot overflow, since 255*255 < 2^16.
- Outside ISSUE, mul_en=0 and mul_a, mul_b, mul_kind are 0.
- Reset, including mid-transaction: the operation is discarded with no partial output.
  - State goes to IDLE.
  - out_valid=0, r=0, busy=0, in_ready=1 (first cycle after reset deassertion).
  - issue_cnt=0, mul_en=0, mul_a=0, mul_b=0, mul_kind=0.
- in_valid while busy is ignored. The requester must hold the request until in_ready.

## Timing
- Accept at edge E0. Quadrants are issued in the cycles following E0, one per set mask bit (n = 1..4).
- out_valid is first high n+1 cycles after the accept cycle: 5 cycles with no skipping, 1 cycle when all quadrants are masked.
- Result-accept edge to next in_ready=1: one cycle.
- Peak throughput is one product per n+2 cycles, reached when out_ready is held high.
- mul_p is sampled at the end of the cycle in which its operands are driven. The shared cell must be purely combinational.

## Configuration
- Macro QUAD_OR_ACC_EN.
- Defined: quadrant terms are combined by bitwise OR of the shifted terms (approximate, carry-free accumulation).
- Undefined: terms are combined by 16-bit addition.
- All other behaviour, including timing, is identical in both builds.

## Structure
- Package mult_sched_pkg holds:
  - the state enum (IDLE, ISSUE, DONE);
  - the kind codes KIND_EXACT=0, KIND_N1=1, KIND_R1=2, KIND_R2=3;
  - the quadrant index constants Q_LL..Q_HH;
  - a function mapping a quadrant index to its shift amount.
- One sub-module, quad_acc: holds the 16-bit accumulator and performs clear, shift and combine (OR or add, per QUAD_OR_ACC_EN).

## Test plan
- Reset, then a=0xFF, b=0xFF, kind=0x00 with an exact bench cell and out_ready=1 → 4 issue cycles, out_valid 5 cycles after accept, r=0xFE01 (add build).
- Same stimulus in the QUAD_OR_ACC_EN build → r = 0xE1 | 0xE10 | 0xE10 | 0xE100 = 0xEFF1.
- SKIP_ZERO=1, a=0x30, b=0x05 → only HL issued, r=0x00F0, issue_cnt +1. Then a=0x00, b=0x5A → no issue cycles, out_valid 1 cycle after accept, r=0.
- out_ready held low for 10 cycles after out_valid → r stable, in_ready=0, requests ignored. Release → IDLE the next cycle.
- kind=0xE4 → mul_kind sequence 0, 1, 2, 3 observed on LL, LH, HL, HH issue cycles.
- rst_n low during the 2nd ISSUE cycle → next cycle IDLE, out_valid=0, issue_cnt=0. A new a=7, b=9 transaction returns r=63.
